adder_chain_sequencer: RTL and testbench
========================================

// Module: adder_chain_sequencer
// PURPOSE
// Sequences the cascaded adder tree to build one neuron pre-activation from N input chunks.
// - Accepts chunks of NUMBER_OF_ADDENDS products over a valid/ready handshake.
// - Drives each chunk into the adder tree.
// - Accumulates the partial sums that come back, then presents one saturated result.
// - Sits between the multiplier array and the activation stage.
// PARAMETERS
// ADDEND_WIDTH       16  width of each product addend (signed)
// NUMBER_OF_ADDENDS  64  addends per chunk; power of two, 2..64
// TREE_SUM_WIDTH     16  width of the tree's saturated sum (signed)
// TREE_LATENCY       1   cycles from addends_out update to matching tree_sum_in; 1..8
// MAX_CHUNKS         16  maximum chunks per result
// RESULT_WIDTH       16  width of the final saturated result (signed)
// PORTS
// clk_in          in   1                             single clock, rising edge
// rst_n_in        in   1                             asynchronous, active-low reset
// start_in        in   1                             one-cycle start pulse; sampled in IDLE only
// num_chunks_in   in   $clog2(MAX_CHUNKS+1)          chunk count; latched on start
// chunk_valid_in  in   1                             chunk_data_in is valid
// chunk_ready_out out  1                             sequencer accepts a chunk this cycle
// chunk_data_in   in   NUMBER_OF_ADDENDS*ADDEND_WIDTH packed signed addends
// addends_out     out  NUMBER_OF_ADDENDS*ADDEND_WIDTH registered drive to the adder tree
// tree_sum_in     in   TREE_SUM_WIDTH                sum returned by the adder tree
// result_valid_out out 1                             result_out is valid
// result_ready_in in   1                             downstream accepts the result
// result_out      out  RESULT_WIDTH                  saturated accumulated sum
// busy_out        out  1                             high in every state except IDLE
// BEHAVIOUR
// - Reset (async assert, sync release) drives every output and register to 0:
//   addends_out, result_out, result_valid_out, chunk_ready_out, busy_out.
//   It also clears the accumulator, both counters and all in-flight valid bits.
//   State goes to IDLE. Reset mid-operation discards all work; no result is emitted.
// - FSM states: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
// - IDLE:
//   - start_in=1: latch count = (num_chunks_in==0 ? 1 : min(num_chunks_in, MAX_CHUNKS)).
//   - Also clear acc, issued and received, then go to FEED.
//   - start_in in any other state is ignored.
// - FEED:
//   - chunk_ready_out=1 (registered from the state).
//   - Handshake on valid&ready: addends_out <= chunk_data_in; issued++.
//   - A launch bit enters a TREE_LATENCY-deep valid delay line.
//   - Go to DRAIN on the handshake where issued == count-1.
//   - With valid=0, addends_out holds its value and no launch bit is inserted.
// - Delay line: its tap asserts exactly TREE_LATENCY cycles after addends_out is updated.
//   - On the tap: acc <= acc + sext(tree_sum_in); received++.
//   - acc is TREE_SUM_WIDTH + $clog2(MAX_CHUNKS) + 1 bits and never wraps.
// - DRAIN: chunk_ready_out=0. Go to DONE on the cycle after received reaches count.
// - DONE:
//   - result_out = sat(acc), clamped to [-2^(RESULT_WIDTH-1), 2^(RESULT_WIDTH-1)-1].
//   - result_valid_out=1. result_out stays stable while valid && !ready.
//   - On valid && ready, go to IDLE with result_valid_out=0 next cycle.
//   - result_out holds its last value.
// - Accumulation is allowed in FEED or DRAIN, so a tap may fire on the same edge as a handshake.
// - Latency: last chunk accepted at edge t -> result_valid_out high at edge t+TREE_LATENCY+2.
// - Throughput: one chunk per cycle in FEED. No overlap of consecutive results.
// STRUCTURE
// - Shared package nn_pkg holds:
//   - typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} seq_state_t;
//   - function saturate(), reused by the activation stage.
// - Sub-module valid_delay_line #(DEPTH): 1-bit shift register with async active-low reset.
// - The adder tree is instantiated by the parent, not inside this block.
// TESTING
// - Bench models the tree as a TREE_LATENCY-cycle delayed saturated sum of addends_out.
// - 1: count=1, all addends=1 -> result_out=64, valid 3 cycles after acceptance (TREE_LATENCY=1).
// - 2: count=4, each chunk sum=1000 -> 4000. Random chunk_valid gaps hold addends_out and give the same result.
// - 3: count=16, every addend=+32767 -> tree saturates to 32767 per chunk -> result_out=32767 (positive clamp).
//   - Same with -32768 -> result_out=-32768.
// - 4: num_chunks_in=0 -> exactly one chunk accepted. num_chunks_in=20 -> clamped to 16 handshakes.
// - 5: hold result_ready_in=0 for 10 cycles -> result_out stable and chunk_ready_out=0. start_in pulses are ignored.
// - 6: assert rst_n_in in DRAIN with 2 chunks in flight -> all outputs 0 immediately, state IDLE.
//   - A fresh count=2 run then yields a clean, correct sum.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared neuron-datapath types and helpers, used by the sequencer and the activation stage.
package nn_pkg;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} seq_state_t;

  // Clamp a signed value into the signed range of a w-bit word (1 <= w <= 64).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned w);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (x > mx) return mx;
    if (x < mn) return mn;
    return x;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit shift register marking in-flight adder-tree launches.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d_in,
  output logic q_out
);

  logic [DEPTH-1:0] vld_pipe_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= d_in;
      for (int i = 1; i < DEPTH; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  assign q_out = vld_pipe_q[DEPTH-1];

endmodule

// File: rtl/adder_chain_sequencer.sv
// Feeds product chunks to the external adder tree and accumulates the returned
// partial sums into one saturated neuron pre-activation.
module adder_chain_sequencer
  import nn_pkg::*;
#(
  parameter int ADDEND_WIDTH      = 16,
  parameter int NUMBER_OF_ADDENDS = 64,
  parameter int TREE_SUM_WIDTH    = 16,
  parameter int TREE_LATENCY      = 1,
  parameter int MAX_CHUNKS        = 16,
  parameter int RESULT_WIDTH      = 16,
  localparam int CNT_W  = $clog2(MAX_CHUNKS + 1),
  localparam int DATA_W = NUMBER_OF_ADDENDS * ADDEND_WIDTH
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             start_in,
  input  logic [CNT_W-1:0]                 num_chunks_in,
  input  logic                             chunk_valid_in,
  output logic                             chunk_ready_out,
  input  logic [DATA_W-1:0]                chunk_data_in,
  output logic [DATA_W-1:0]                addends_out,
  input  logic signed [TREE_SUM_WIDTH-1:0] tree_sum_in,
  output logic                             result_valid_out,
  input  logic                             result_ready_in,
  output logic signed [RESULT_WIDTH-1:0]   result_out,
  output logic                             busy_out
);

  localparam int ACC_W = TREE_SUM_WIDTH + $clog2(MAX_CHUNKS) + 1;

  seq_state_t                     state_q;
  logic [CNT_W-1:0]               count_q, issued_q, received_q;
  logic [CNT_W-1:0]               count_d;
  logic signed [ACC_W-1:0]        acc_q;
  logic                           launch_q;
  logic                           ready_q, rvalid_q, busy_q;
  logic [DATA_W-1:0]              addends_q;
  logic signed [RESULT_WIDTH-1:0] result_q;
  logic signed [63:0]             sat64;
  logic                           hs, tap;

  assign hs = chunk_valid_in & ready_q;

  always_comb begin
    count_d = num_chunks_in;
    if (num_chunks_in == '0) count_d = CNT_W'(1);
    else if (num_chunks_in > CNT_W'(MAX_CHUNKS)) count_d = CNT_W'(MAX_CHUNKS);
  end

  assign sat64 = saturate(64'(acc_q), RESULT_WIDTH);

  // launch_q marks the cycle addends_out changed, so the tap lands exactly
  // TREE_LATENCY cycles after the tree saw the new chunk.
  valid_delay_line #(.DEPTH(TREE_LATENCY)) u_vdl (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .d_in    (launch_q),
    .q_out   (tap)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      count_q    <= '0;
      issued_q   <= '0;
      received_q <= '0;
      acc_q      <= '0;
      launch_q   <= 1'b0;
      ready_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      addends_q  <= '0;
      result_q   <= '0;
    end else begin
      launch_q <= hs;
      if (hs) begin
        addends_q <= chunk_data_in;
        issued_q  <= issued_q + CNT_W'(1);
      end
      if (tap && (state_q == FEED || state_q == DRAIN)) begin
        acc_q      <= acc_q + ACC_W'(tree_sum_in);
        received_q <= received_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: if (start_in) begin
          count_q    <= count_d;
          acc_q      <= '0;
          issued_q   <= '0;
          received_q <= '0;
          ready_q    <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= FEED;
        end
        FEED: if (hs && issued_q == count_q - CNT_W'(1)) begin
          ready_q <= 1'b0;
          state_q <= DRAIN;
        end
        DRAIN: if (received_q == count_q) begin
          result_q <= sat64[RESULT_WIDTH-1:0];
          rvalid_q <= 1'b1;
          state_q  <= DONE;
        end
        DONE: if (result_ready_in) begin
          rvalid_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chunk_ready_out  = ready_q;
  assign addends_out      = addends_q;
  assign result_valid_out = rvalid_q;
  assign result_out       = result_q;
  assign busy_out         = busy_q;

endmodule

// File: tb/tb_adder_chain_sequencer.sv
// Self-checking bench: behavioural tree model plus a chunk-level accumulation model.
module tb_adder_chain_sequencer;
  localparam int AW = 16, N = 64, TW = 16, TL = 1, MC = 16, RW = 16;
  localparam int CW = $clog2(MC + 1), DW = N * AW;
  localparam int P_ONES = 0, P_1000 = 1, P_MAXP = 2, P_MAXN = 3, P_RAND = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, cvalid = 1'b0, rready = 1'b0;
  logic [CW-1:0] num = '0;
  logic [DW-1:0] cdata = '0;
  logic cready, rvalid, busy;
  logic [DW-1:0] addends;
  logic signed [TW-1:0] tree_sum;
  logic signed [RW-1:0] result;

  always #5 clk = ~clk;

  adder_chain_sequencer #(
    .ADDEND_WIDTH(AW), .NUMBER_OF_ADDENDS(N), .TREE_SUM_WIDTH(TW),
    .TREE_LATENCY(TL), .MAX_CHUNKS(MC), .RESULT_WIDTH(RW)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .num_chunks_in(num),
    .chunk_valid_in(cvalid), .chunk_ready_out(cready), .chunk_data_in(cdata),
    .addends_out(addends), .tree_sum_in(tree_sum), .result_valid_out(rvalid),
    .result_ready_in(rready), .result_out(result), .busy_out(busy)
  );

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc++;

  function automatic longint sat(longint x, int w);
    longint mx = (64'sd1 <<< (w - 1)) - 1;
    if (x > mx) return mx;
    if (x < -mx - 1) return -mx - 1;
    return x;
  endfunction

  function automatic longint tsum(logic [DW-1:0] d);
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'($signed(d[i*AW +: AW]));
    return sat(s, TW);
  endfunction

  // Adder tree: TL-cycle delayed saturated sum of addends_out.
  logic signed [TW-1:0] tree_pipe [TL];
  initial for (int i = 0; i < TL; i++) tree_pipe[i] = '0;
  always @(posedge clk) begin
    tree_pipe[0] <= TW'(tsum(addends));
    for (int i = 1; i < TL; i++) tree_pipe[i] <= tree_pipe[i-1];
  end
  assign tree_sum = tree_pipe[TL-1];

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] gen(int pat);
    logic [DW-1:0] d = '0;
    int s = 0, a;
    for (int i = 0; i < N; i++) begin
      case (pat)
        P_ONES: a = 1;
        P_1000: begin
          if (i < N - 1) begin a = int'($urandom_range(200)) - 100; s += a; end
          else a = 1000 - s;
        end
        P_MAXP: a = 32767;
        P_MAXN: a = -32768;
        default: a = int'($urandom_range(65535)) - 32768;
      endcase
      d[i*AW +: AW] = a[AW-1:0];
    end
    return d;
  endfunction

  // One complete operation; holds result_ready low for `hold` cycles after valid.
  task automatic run(input int n_req, input int pat, input int gap, input int hold,
                     output int n_acc, output longint r_dut, output longint r_mod,
                     output int lat);
    longint acc = 0;
    logic [DW-1:0] last = '0, d;
    int hs_edge = 0;
    bit got = 0;
    n_acc = 0;
    @(negedge clk);
    start = 1'b1; num = CW'(n_req);
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 1000; b++) begin
      if (n_acc > 0) chk("addends_hold", longint'(addends == last), 1);
      if (rvalid) begin got = 1; break; end
      d = gen(pat);
      cvalid = ($urandom_range(99) >= gap);
      cdata = d;
      if (cvalid && cready) begin
        n_acc++; acc += tsum(d); last = d; hs_edge = cyc + 1;
      end
      @(negedge clk);
    end
    cvalid = 1'b0;
    if (!got) chk("result_timeout", 0, 1);
    lat = cyc - hs_edge;
    r_dut = longint'(result);
    r_mod = sat(acc, RW);
    chk("ready_low_in_done", longint'(cready), 0);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; num = CW'(3);
      @(negedge clk);
      chk("hold_result_stable", longint'(result), r_dut);
      chk("hold_valid", longint'(rvalid), 1);
      chk("hold_ready_low", longint'(cready), 0);
    end
    start = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("valid_drop", longint'(rvalid), 0);
    chk("busy_drop", longint'(busy), 0);
    chk("result_holds", longint'(result), r_dut);
  endtask

  typedef struct {
    int num; int pat; int gap; int hold; int exp_n; bit use_c; longint exp_r;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int n_acc, lat, en;
    longint rd, rm;
    vecs[0] = '{1,  P_ONES, 0,  0,  1,  1, 64};
    vecs[1] = '{4,  P_1000, 0,  0,  4,  1, 4000};
    vecs[2] = '{4,  P_1000, 50, 0,  4,  1, 4000};
    vecs[3] = '{16, P_MAXP, 0,  0,  16, 1, 32767};
    vecs[4] = '{16, P_MAXN, 0,  0,  16, 1, -32768};
    vecs[5] = '{0,  P_ONES, 0,  0,  1,  1, 64};
    vecs[6] = '{20, P_ONES, 20, 0,  16, 1, 1024};
    vecs[7] = '{2,  P_1000, 0,  10, 2,  1, 2000};
    vecs[8] = '{3,  P_RAND, 30, 0,  3,  0, 0};

    #1;
    chk("rst_addends", longint'(addends == '0), 1);
    chk("rst_result", longint'(result), 0);
    chk("rst_valid", longint'(rvalid), 0);
    chk("rst_ready", longint'(cready), 0);
    chk("rst_busy", longint'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      run(vecs[k].num, vecs[k].pat, vecs[k].gap, vecs[k].hold, n_acc, rd, rm, lat);
      chk($sformatf("v%0d_handshakes", k), n_acc, vecs[k].exp_n);
      chk($sformatf("v%0d_latency", k), lat, TL + 2);
      chk($sformatf("v%0d_model", k), rd, rm);
      if (vecs[k].use_c) chk($sformatf("v%0d_const", k), rd, vecs[k].exp_r);
    end

    for (int r = 0; r < 8; r++) begin
      int nr = int'($urandom_range(20));
      en = (nr == 0) ? 1 : (nr > MC ? MC : nr);
      run(nr, (r % 2) ? P_RAND : P_1000, int'($urandom_range(60)), 0, n_acc, rd, rm, lat);
      chk($sformatf("r%0d_handshakes", r), n_acc, en);
      chk($sformatf("r%0d_latency", r), lat, TL + 2);
      chk($sformatf("r%0d_model", r), rd, rm);
    end

    // Reset while two chunks are still working through the tree.
    @(negedge clk);
    start = 1'b1; num = CW'(2);
    @(negedge clk);
    start = 1'b0;
    cvalid = 1'b1; cdata = gen(P_1000);
    @(negedge clk);
    cdata = gen(P_1000);
    @(negedge clk);
    cvalid = 1'b0;
    chk("mid_busy", longint'(busy), 1);
    chk("mid_ready_low", longint'(cready), 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_addends", longint'(addends == '0), 1);
    chk("mrst_result", longint'(result), 0);
    chk("mrst_valid", longint'(rvalid), 0);
    chk("mrst_ready", longint'(cready), 0);
    chk("mrst_busy", longint'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_result", longint'(rvalid), 0);
    run(2, P_1000, 0, 0, n_acc, rd, rm, lat);
    chk("post_rst_handshakes", n_acc, 2);
    chk("post_rst_result", rd, 2000);
    chk("post_rst_latency", lat, TL + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
